// File: rtl/ps2_pkg.sv
// Shared constants and state types for the PS/2 scan-code receive path.
// Optional build macro: PS2_EXTENDED_OUT_EN (adds the 'extended' output on the top).
package ps2_pkg;

    localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS   = 11;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_GOT_F0,
        DEC_GOT_E0,
        DEC_GOT_E0F0
    } dec_state_t;

    typedef enum logic {
        FRM_IDLE,
        FRM_SHIFT
    } frame_state_t;

    // Frame layout, index 0 first on the wire: start, d0..d7, parity, stop.
    function automatic logic frame_good(input logic [PS2_FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: input synchronizers, falling-edge
// detect, LSB-first shift, start/stop/odd-parity check and mid-frame watchdog.
// Emits one-cycle o_byte_ok / o_frame_err strobes the cycle after the 11th fall.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned SYNC_STAGES    = 2
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_ok,
    output logic       o_frame_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0]    r_clk_sync;
    logic [SYNC_STAGES-1:0]    r_data_sync;
    logic                      r_clk_prev;
    logic                      w_clk_s;
    logic                      w_data_s;
    logic                      w_fall;
    logic [PS2_FRAME_BITS-2:0] r_shift;
    logic [PS2_FRAME_BITS-1:0] w_frame;
    logic [3:0]                r_cnt;
    logic [WD_W-1:0]           r_wd;
    frame_state_t              r_state;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;
    // Only ten bits are stored; the eleventh is checked straight off the synchronizer.
    assign w_frame  = {w_data_s, r_shift};

    // Synchronize both PS/2 lines (idle high) and keep the previous clock sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    // Frame FSM with watchdog; check result is registered as a one-cycle strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= FRM_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_wd        <= '0;
            o_byte      <= '0;
            o_byte_ok   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_byte_ok   <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                FRM_IDLE: begin
                    r_wd <= '0;
                    if (w_fall) begin
                        r_shift <= {w_data_s, r_shift[PS2_FRAME_BITS-2:1]};
                        r_cnt   <= 4'd1;
                        r_state <= FRM_SHIFT;
                    end
                end
                FRM_SHIFT: begin
                    if (w_fall) begin
                        r_wd <= '0;
                        if (r_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= FRM_IDLE;
                            if (frame_good(w_frame)) begin
                                o_byte    <= w_frame[8:1];
                                o_byte_ok <= 1'b1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end else begin
                            r_shift <= {w_data_s, r_shift[PS2_FRAME_BITS-2:1]};
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        r_wd        <= '0;
                        r_cnt       <= '0;
                        r_state     <= FRM_IDLE;
                        o_frame_err <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: r_state <= FRM_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard scan-code decoder: frames the raw PS/2 stream, strips F0/E0
// prefixes and presents a held scanCode/makeBreak pair with a valid strobe.
// Optional build macro: PS2_EXTENDED_OUT_EN adds the held 'extended' flag.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned SYNC_STAGES    = 2
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scanCode,
    output logic       makeBreak,
    output logic       valid,
    output logic       err
`ifdef PS2_EXTENDED_OUT_EN
    ,
    output logic       extended
`endif
);

    logic [7:0] w_byte;
    logic       w_byte_ok;
    logic       w_frame_err;
    logic       w_emit;
    logic       w_make;
    dec_state_t w_next;
    dec_state_t r_state;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_byte      (w_byte),
        .o_byte_ok   (w_byte_ok),
        .o_frame_err (w_frame_err)
    );

    // The frame strobe is already registered and never coincides with a byte.
    assign err = w_frame_err;

    // Prefix tracking: decide next decode state and whether a received byte emits.
    always_comb begin
        w_emit = 1'b0;
        w_make = 1'b1;
        w_next = r_state;
        case (r_state)
            DEC_BASE: begin
                if (w_byte == PS2_BREAK_PREFIX)    w_next = DEC_GOT_F0;
                else if (w_byte == PS2_EXT_PREFIX) w_next = DEC_GOT_E0;
                else                               w_emit = 1'b1;
            end
            DEC_GOT_E0: begin
                if (w_byte == PS2_BREAK_PREFIX)    w_next = DEC_GOT_E0F0;
                else if (w_byte == PS2_EXT_PREFIX) w_next = DEC_GOT_E0;
                else begin
                    w_emit = 1'b1;
                    w_next = DEC_BASE;
                end
            end
            DEC_GOT_F0, DEC_GOT_E0F0: begin
                w_emit = 1'b1;
                w_make = 1'b0;
                w_next = DEC_BASE;
            end
            default: w_next = DEC_BASE;
        endcase
    end

`ifdef PS2_EXTENDED_OUT_EN
    logic w_ext;
    assign w_ext = (r_state == DEC_GOT_E0) || (r_state == DEC_GOT_E0F0);
`endif

    // Decode FSM and held output registers; a frame error drops any pending prefix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= DEC_BASE;
            scanCode  <= '0;
            makeBreak <= 1'b0;
            valid     <= 1'b0;
`ifdef PS2_EXTENDED_OUT_EN
            extended  <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            if (w_frame_err) begin
                r_state <= DEC_BASE;
            end else if (w_byte_ok) begin
                r_state <= w_next;
                if (w_emit) begin
                    scanCode  <= w_byte;
                    makeBreak <= w_make;
                    valid     <= 1'b1;
`ifdef PS2_EXTENDED_OUT_EN
                    extended  <= w_ext;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: the stimulus process bit-bangs PS/2
// frames and pushes expected events from a byte-level reference model; a
// monitor pops and checks on every valid/err strobe, including its cycle.
module tb_ps2_scan_decoder;

    localparam int unsigned TO = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scanCode;
    logic       makeBreak;
    logic       valid;
    logic       err;
`ifdef PS2_EXTENDED_OUT_EN
    logic       extended;
`endif

    ps2_scan_decoder #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scanCode  (scanCode),
        .makeBreak (makeBreak),
        .valid     (valid),
        .err       (err)
`ifdef PS2_EXTENDED_OUT_EN
        ,
        .extended  (extended)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         mb;
        bit         ext;
        int         cmin;
        int         cmax;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: pending prefixes and the currently held outputs.
    bit         m_brk = 0;
    bit         m_ext = 0;
    logic [7:0] m_code = 8'h00;
    bit         m_mb = 0;
    bit         m_xt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_code = 8'h00; m_mb = 0; m_xt = 0;
    endtask

    task automatic push_err(input int cmin, input int cmax);
        exp_t e;
        m_brk = 0; m_ext = 0;
        e.is_err = 1; e.code = m_code; e.mb = m_mb; e.ext = m_xt;
        e.cmin = cmin; e.cmax = cmax;
        q.push_back(e);
    endtask

    // c = cycle count at the 11th falling edge drive. Two sync flops plus the
    // edge-detect flop put the fall strobe 2 cycles later; err follows one
    // cycle after that, valid two cycles after.
    task automatic model_frame(input logic [7:0] b, input bit ok, input int c);
        exp_t e;
        if (!ok) begin
            push_err(c + 3, c + 3);
            return;
        end
        if (m_brk || (b != 8'hF0 && b != 8'hE0)) begin
            m_code = b;
            m_mb   = !m_brk;
            m_xt   = m_ext;
            m_brk  = 0;
            m_ext  = 0;
            e.is_err = 0; e.code = m_code; e.mb = m_mb; e.ext = m_xt;
            e.cmin = c + 4; e.cmax = c + 4;
            q.push_back(e);
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            m_ext = 1;
        end
    endtask

    // Drive nbits of a frame; expectations are pushed at the relevant fall so
    // the monitor always finds them queued before the DUT responds.
    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_start,
                        input bit bad_stop, input int nbits, input int hp, input bit exp_to);
        logic [10:0] f;
        int c;
        f = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (hp) @(posedge clk);
            #1 ps2_clk = 1'b0;
            c = cyc;
            if (i == 10) model_frame(b, !(bad_par || bad_start || bad_stop), c);
            else if (exp_to && i == nbits - 1) push_err(c + int'(TO), c + int'(TO) + 6);
            repeat (hp) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic good(input logic [7:0] b);
        send(b, 0, 0, 0, 11, 20, 0);
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_scanCode"}, 32'(scanCode), 32'(m_code));
        chk({tag, "_makeBreak"}, 32'(makeBreak), 32'(m_mb));
`ifdef PS2_EXTENDED_OUT_EN
        chk({tag, "_extended"}, 32'(extended), 32'(m_xt));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_scanCode"}, 32'(scanCode), 32'h00);
        chk({tag, "_makeBreak"}, 32'(makeBreak), 32'h0);
        chk({tag, "_valid"}, 32'(valid), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
`ifdef PS2_EXTENDED_OUT_EN
        chk({tag, "_extended"}, 32'(extended), 32'h0);
`endif
    endtask

    // Monitor: every strobe must match the oldest expectation, at its cycle.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid === 1'b1 || err === 1'b1)) begin
            chk("valid_err_exclusive", 32'(valid & err), 32'h0);
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got valid=%0b err=%0b code=%02h, required no strobe",
                         valid, err, scanCode);
            end else begin
                me = q.pop_front();
                chk("strobe_kind_err", 32'(err), 32'(me.is_err));
                chk("strobe_scanCode", 32'(scanCode), 32'(me.code));
                chk("strobe_makeBreak", 32'(makeBreak), 32'(me.mb));
`ifdef PS2_EXTENDED_OUT_EN
                chk("strobe_extended", 32'(extended), 32'(me.ext));
`endif
                n_tests++;
                if (cyc < me.cmin || cyc > me.cmax) begin
                    n_fail++;
                    $display("FAIL strobe_cycle: got %0d, required %0d..%0d", cyc, me.cmin, me.cmax);
                end
            end
        end
    end

    initial begin
        int r, hp;
        logic [7:0] b;
        bit bp, bs, bt;

        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single make.
        good(8'h29);
        check_held("make_29");

        // Break prefix then code.
        good(8'hF0);
        check_held("after_F0");
        good(8'h29);
        check_held("break_29");

        // Parity error leaves outputs alone, then a clean frame.
        send(8'h29, 1, 0, 0, 11, 20, 0);
        check_held("bad_parity");
        good(8'h1C);
        check_held("make_1C");

        // Framing errors on start and stop bits.
        send(8'h33, 0, 1, 0, 11, 20, 0);
        send(8'h33, 0, 0, 1, 11, 20, 0);
        check_held("bad_framing");

        // A break prefix followed by a bad frame is forgotten.
        good(8'hF0);
        send(8'h44, 1, 0, 0, 11, 20, 0);
        good(8'h29);
        check_held("err_clears_prefix");

        // Watchdog: five bits then silence.
        send(8'h5A, 0, 0, 0, 5, 20, 1);
        repeat (TO + 20) @(posedge clk);
        #1 check_held("timeout");
        good(8'h29);
        check_held("after_timeout");

        // Extended prefix handling, E0 75 then E0 F0 75.
        good(8'hE0);
        good(8'h75);
        check_held("ext_make_75");
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        check_held("ext_break_75");

        // Reset mid-frame during an F0 loses the prefix.
        send(8'hF0, 0, 0, 0, 6, 20, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset_midframe");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        good(8'h29);
        check_held("after_reset_29");

        // Randomized traffic, including stray prefixes and occasional bad frames.
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)       b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            bp = 0; bs = 0; bt = 0;
            case ($urandom_range(0, 11))
                0: bp = 1;
                1: bs = 1;
                2: bt = 1;
                default: ;
            endcase
            hp = int'($urandom_range(15, 25));
            send(b, bp, bs, bt, 11, hp, 0);
        end
        check_held("random_end");

        // Every queued expectation must have been seen.
        for (int k = 0; k < 1000 && q.size() != 0; k++) @(posedge clk);
        #1 chk("queue_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Receives the raw PS/2 keyboard serial stream (ps2_clk/ps2_data pins).
- Frames 11-bit PS/2 device-to-host packets and strips the F0 (break) and E0 (extended) prefixes.
- Drives the held scanCode/makeBreak pair plus a one-cycle valid strobe that every per-key edge detector in the game logic consumes.
- Sits between the De1-SoC PS/2 pins and all key-action modules.

Parameters:
- TIMEOUT_CYCLES, 10000, system clocks with no ps2_clk falling edge mid-frame before the frame is aborted (200 us at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous PS/2 input (legal range 2..4).

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
- scanCode  output  8  last decoded base scan code, held until the next decoded key event.
- makeBreak  output  1  1 = make (pressed), 0 = break (released); held with scanCode.
- valid  output  1  one-cycle strobe, high in the cycle scanCode/makeBreak update.
- err  output  1  one-cycle strobe on a framing, parity or timeout error.

Behaviour:
- Reset, asynchronous and active-low:
  - scanCode=8'h00, makeBreak=0, valid=0, err=0.
  - Synchronizers preset to 1 (bus idle).
  - Frame FSM goes to IDLE with bit count 0; decode FSM goes to BASE.
  - Reset mid-frame discards partial data; no valid or err is produced.
- Input conditioning:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge is synchronized previous=1 and current=0, giving a one-cycle fall strobe.
  - Data is sampled on the fall strobe.
- Frame FSM, states IDLE and SHIFT:
  - IDLE to SHIFT on fall: captures the start bit, count=1.
  - SHIFT: each fall shifts in a bit, LSB first. Bit order is start, d0..d7, parity, stop (11 bits total).
  - On the 11th fall the frame is checked: start==0, stop==1, and odd parity (XOR of d0..d7 and parity bit ==1).
  - Pass: the byte is handed to the decoder in the next cycle.
  - Fail: err pulses in the next cycle and the decode FSM is forced to BASE.
  - Either way the frame FSM returns to IDLE.
  - Watchdog: the counter resets on every fall. If it reaches TIMEOUT_CYCLES while in SHIFT, the frame FSM goes to IDLE, err pulses, and the decode FSM goes to BASE.
  - Watchdog is inactive in IDLE.
- Decode FSM, states BASE, GOT_F0, GOT_E0, GOT_E0F0:
  - BASE: F0 goes to GOT_F0; E0 goes to GOT_E0; any other byte emits make.
  - GOT_E0: F0 goes to GOT_E0F0; E0 stays in GOT_E0; any other byte emits make (extended) and returns to BASE.
  - GOT_F0 / GOT_E0F0: any byte emits break and returns to BASE. A byte of E0/F0 here is treated as the code itself.
- Emit means scanCode<=byte, makeBreak<=make?1:0, valid=1 for one cycle, all in the same cycle.
- Latency: valid rises 2 clk cycles after the cycle holding the 11th fall strobe (1 cycle frame check, 1 cycle decode).
- Typematic repeats re-emit make with an identical scanCode, each with its own valid strobe. Consumers key off value changes or the strobe.
- Prefix bytes alone never update the outputs.
- A byte never produces valid and err together.
- Host-to-device commands (LED/reset) are out of scope; the block never drives ps2_clk or ps2_data.

Optional Feature:
- Macro PS2_EXTENDED_OUT_EN.
- Defined: adds output port extended (1 bit). It is held and updated with scanCode; 1 when the event came through GOT_E0 or GOT_E0F0, reset 0.
- Undefined: no extended port. E0 prefixes are still tracked and stripped, so extended keys alias to their base code (E0 75 reads as 75).

Decomposition:
- Package ps2_pkg:
  - PS2_BREAK_PREFIX=8'hF0, PS2_EXT_PREFIX=8'hE0.
  - Frame length constant 11.
  - Decode-state enum type.
- Key scan-code macros (SPACE_C etc.) stay in GLOBAL.sv.
- One sub-module, ps2_rx_frame. It owns the synchronizers, fall detect, shift register, parity/framing check and watchdog. It outputs byte[7:0], byte_ok and frame_err strobes.
- The top level owns the decode FSM and the output registers.

Test Plan:
- Frame 0x29 (bits 0,1,0,0,1,0,1,0,0,0,1) at a 12.5 kHz ps2_clk -> valid pulse, scanCode=8'h29, makeBreak=1, err=0, exactly 2 cycles after the 11th fall.
- Frames F0 then 29 -> no valid after F0; one valid after 29 with scanCode=8'h29, makeBreak=0.
- Frame 0x29 with the parity bit flipped to 1 -> err pulse, no valid, outputs unchanged. A following good 0x1C frame gives scanCode=8'h1C, makeBreak=1.
- 5 bits sent then ps2_clk held high for TIMEOUT_CYCLES -> err pulse at the timeout. A following full 0x29 frame decodes correctly.
- With PS2_EXTENDED_OUT_EN defined: E0 75, then E0 F0 75 -> first valid gives 75/make/extended=1; second gives 75/break/extended=1.
- Assert rst_n low after 6 bits of F0, then send 0x29 -> all outputs at reset values during reset; after release 0x29 decodes as make, so the break prefix was lost.
